// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped cache line-refill engine.
package cache_pkg;

    localparam int LINE_WORDS  = 16;
    localparam int WORD_W      = 32;
    localparam int LINE_W      = LINE_WORDS * WORD_W;
    localparam int OFFSET_BITS = 6;
    localparam int INDEX_BITS  = 5;

    // Byte-offset bits within a line; cleared to form the line base address.
    localparam logic [31:0] OFFSET_MASK = (32'd1 << OFFSET_BITS) - 32'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } refill_state_t;

    typedef logic [3:0] beat_t;

    localparam beat_t LAST_BEAT = beat_t'(LINE_WORDS - 1);

    // Cache set index selected by a byte address.
    function automatic logic [INDEX_BITS-1:0] line_index(input logic [31:0] addr);
        return addr[OFFSET_BITS +: INDEX_BITS];
    endfunction

endpackage

// File: rtl/cache_refill_if.sv
// Miss/memory/cache-write signal bundle around the refill engine.
interface cache_refill_if;
    import cache_pkg::*;

    logic              miss_req;
    logic [31:0]       miss_addr;
    logic              stall;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;
    logic              write_cache;
    logic [31:0]       cache_addr;
    logic [LINE_W-1:0] cache_data_in;
    logic              refill_done;

    // Refill engine side.
    modport slave (
        input  miss_req, miss_addr, mem_ack, mem_rdata,
        output stall, mem_req, mem_addr, write_cache, cache_addr, cache_data_in, refill_done
    );

    // Lookup / memory / cache side driving the engine.
    modport master (
        output miss_req, miss_addr, mem_ack, mem_rdata,
        input  stall, mem_req, mem_addr, write_cache, cache_addr, cache_data_in, refill_done
    );

endinterface

// File: rtl/line_assembler.sv
// Collects the 16 memory words of a line into slots; word 0 sits in the MSBs.
module line_assembler
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  beat_t             sel,
    input  logic [WORD_W-1:0] data,
    output logic [LINE_W-1:0] line
);

    logic [WORD_W-1:0] slot [LINE_WORDS];

    // Store an acknowledged word into its slot; slots need no reset since every
    // slot is rewritten before a line is ever handed to the cache.
    always_ff @(posedge clk) begin
        if (load) begin
            slot[sel] <= data;
        end
    end

    // Pack slots into the line, forwarding the word being loaded so the final
    // beat is visible on the same edge it is captured.
    always_comb begin
        line = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (load && sel == beat_t'(k)) begin
                line[LINE_W-1-WORD_W*k -: WORD_W] = data;
            end else begin
                line[LINE_W-1-WORD_W*k -: WORD_W] = slot[k];
            end
        end
    end

endmodule

// File: rtl/cache_refill.sv
// Line-refill engine: fetches 16 words of a missing line and writes the block
// into the cache with a single write_cache strobe.
module cache_refill
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    cache_refill_if.slave bus
);

    refill_state_t     state;
    beat_t             beat;
    logic [31:0]       base;
    logic              mem_req_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       cache_addr_q;
    logic [LINE_W-1:0] cache_data_q;
    logic [LINE_W-1:0] line;
    logic              beat_ack;
    logic              last_ack;
    logic              accept;
    logic              stall_c;

    assign accept   = (state == IDLE) && bus.miss_req;
    assign beat_ack = (state == REQ) && bus.mem_ack;
    assign last_ack = beat_ack && (beat == LAST_BEAT);

    line_assembler u_line_assembler (
        .clk  (clk),
        .load (beat_ack),
        .sel  (beat),
        .data (bus.mem_rdata),
        .line (line)
    );

    // Refill sequencing: latch the line base, count acknowledged beats.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            beat  <= '0;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_req) begin
                        base  <= bus.miss_addr & ~OFFSET_MASK;
                        beat  <= '0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        beat <= beat + beat_t'(1);
                        if (beat == LAST_BEAT) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Registered memory request; address advances on the edge after each ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else if (accept) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= bus.miss_addr & ~OFFSET_MASK;
        end else if (beat_ack) begin
            if (last_ack) begin
                mem_req_q <= 1'b0;
            end else begin
                mem_addr_q <= mem_addr_q + 32'd4;
            end
        end
    end

    // Stage the finished line and its base on the final ack; held until the next line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cache_addr_q <= '0;
            cache_data_q <= '0;
        end else if (last_ack) begin
            cache_addr_q <= base;
            cache_data_q <= line;
        end
    end

    // CPU hold: pending miss in IDLE, busy through the write, released in DONE.
    always_comb begin
        stall_c = 1'b0;
        case (state)
            IDLE:        stall_c = bus.miss_req;
            REQ, WRITE:  stall_c = 1'b1;
            default:     stall_c = 1'b0;
        endcase
    end

    assign bus.stall         = stall_c;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.write_cache   = (state == WRITE);
    assign bus.cache_addr    = cache_addr_q;
    assign bus.cache_data_in = cache_data_q;
    assign bus.refill_done   = (state == DONE);

endmodule

// File: tb/tb_cache_refill.sv
// Bench for cache_refill: table-driven refills, abort/reset sequences and
// randomized refills checked against a transaction-level memory/line model.
module tb_cache_refill;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic reset;

    cache_refill_if bus ();

    cache_refill dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit          use_hash = 1'b0;
    logic [31:0] salt     = '0;

    typedef struct {
        logic [31:0] addr;
        int          wait_cyc;
        bit          chain;
        logic [31:0] exp_cache_addr;
        int          exp_latency;
        int          exp_index;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents model.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (use_hash) return (a * 32'h9E37_79B1) ^ salt;
        return 32'hA000_0000 | {28'h0, a[5:2]};
    endfunction

    // Expected cache line for a base: word k of memory at bits [511-32k -: 32].
    function automatic logic [511:0] model_line(input logic [31:0] b);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) l[511-32*k -: 32] = mem_data(b + 32'(4*k));
        return l;
    endfunction

    task automatic drive_spurious();
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = 32'hDEAD_BEEF;
    endtask

    // One full refill, entered at a negedge with the DUT in IDLE (chain=0)
    // or just after observing refill_done (chain=1).
    task automatic do_refill(input logic [31:0] addr, input int wait_cyc, input bit rand_wait,
                             input bit chain, output int latency, output int req_cycles,
                             output logic [31:0] got_addr, output logic [511:0] got_line);
        logic [31:0] b;
        int beat, wait_left, idle_n, cyc, writes, write_at, sum_wait;
        bit done;
        b = addr & 32'hFFFF_FFC0;
        beat = 0; idle_n = 0; cyc = 0; writes = 0; write_at = -1; sum_wait = 0; done = 0;
        latency = -1; req_cycles = 0; got_addr = '0; got_line = '0;
        if (!chain) begin
            bus.miss_req = 1'b0;
            drive_spurious();
            @(negedge clk);
            chk("idle_stall", bus.stall, 0);
            chk("idle_mem_req", bus.mem_req, 0);
        end
        bus.miss_req  = 1'b1;
        bus.miss_addr = addr;
        drive_spurious();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.mem_req) break;
            idle_n++;
            chk("pending_stall", bus.stall, 1);
            drive_spurious();
        end
        chk("accept_delay", idle_n, chain ? 1 : 0);
        wait_left = rand_wait ? $urandom_range(0, 3) : wait_cyc;
        sum_wait  = wait_left;
        cyc = 1;
        while (!done && cyc < 400) begin
            if (bus.mem_req) begin
                req_cycles++;
                chk("mem_addr", bus.mem_addr, b + 32'(4*beat));
                chk("stall_req", bus.stall, 1);
                if (wait_left == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_data(b + 32'(4*beat));
                    beat++;
                    if (beat < 16) begin
                        wait_left = rand_wait ? $urandom_range(0, 3) : wait_cyc;
                        sum_wait += wait_left;
                    end
                end else begin
                    wait_left--;
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end else if (bus.refill_done) begin
                latency = cyc;
                chk("stall_done", bus.stall, 0);
                chk("write_then_done", write_at, cyc - 1);
                done = 1'b1;
                bus.miss_req = 1'b0;
                drive_spurious();
            end else begin
                drive_spurious();
            end
            if (bus.write_cache) begin
                writes++;
                write_at = cyc;
                got_addr = bus.cache_addr;
                got_line = bus.cache_data_in;
                chk("stall_write", bus.stall, 1);
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("refill_completes", done, 1);
        chk("write_pulses", writes, 1);
        chk("req_cycles", req_cycles, 16 + sum_wait);
        chk("latency", latency, 18 + sum_wait);
        chk("cache_addr", got_addr, b);
        chk("line", got_line, model_line(b));
    endtask

    // Zero-wait refill aborted by reset asserted at request sample reset_sample
    // (sample s carries the request for beat s-1).
    task automatic abort_refill(input logic [31:0] addr, input int reset_sample);
        logic [31:0] b;
        bit seen;
        b = addr & 32'hFFFF_FFC0;
        bus.miss_req  = 1'b1;
        bus.miss_addr = addr;
        bus.mem_ack   = 1'b0;
        for (int s = 1; s <= reset_sample; s++) begin
            @(negedge clk);
            chk("abort_mem_req", bus.mem_req, 1);
            chk("abort_mem_addr", bus.mem_addr, b + 32'(4*(s-1)));
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_data(b + 32'(4*(s-1)));
            if (s == reset_sample) reset = 1'b0;
        end
        bus.miss_req = 1'b0;
        @(negedge clk);
        chk("abort_req_low", bus.mem_req, 0);
        chk("abort_addr_zero", bus.mem_addr, 0);
        chk("abort_write", bus.write_cache, 0);
        chk("abort_cache_addr", bus.cache_addr, 0);
        chk("abort_cache_data", bus.cache_data_in, 0);
        chk("abort_stall", bus.stall, 0);
        reset = 1'b1;
        bus.mem_ack = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            seen |= bus.write_cache | bus.refill_done | bus.mem_req;
        end
        chk("abort_quiet", seen, 0);
    endtask

    initial begin
        logic [31:0]  ga;
        logic [511:0] gl;
        logic [511:0] line_t2;
        logic [31:0]  last_addr;
        logic [511:0] last_line;
        int lat, rq;
        bit seen;

        vecs[0] = '{32'h0000_1234, 0, 1'b0, 32'h0000_1200, 18, 8};
        vecs[1] = '{32'h0000_1234, 3, 1'b0, 32'h0000_1200, 66, 8};
        vecs[2] = '{32'h0000_07C0, 0, 1'b0, 32'h0000_07C0, 18, 31};
        vecs[3] = '{32'h0000_0800, 0, 1'b1, 32'h0000_0800, 18, 0};
        vecs[4] = '{32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFC0, 34, 31};
        line_t2 = '0;
        last_addr = '0;
        last_line = '0;

        // Reset held with a pending miss.
        reset         = 1'b0;
        bus.miss_req  = 1'b1;
        bus.miss_addr = 32'h0000_1234;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mem_req", bus.mem_req, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_write", bus.write_cache, 0);
            chk("rst_cache_addr", bus.cache_addr, 0);
            chk("rst_cache_data", bus.cache_data_in, 0);
            chk("rst_done", bus.refill_done, 0);
            chk("rst_stall", bus.stall, 1);
        end
        reset = 1'b1;
        bus.miss_req = 1'b0;

        // Table-driven refills.
        for (int i = 0; i < 5; i++) begin
            do_refill(vecs[i].addr, vecs[i].wait_cyc, 1'b0, vecs[i].chain, lat, rq, ga, gl);
            chk("tbl_latency", lat, vecs[i].exp_latency);
            chk("tbl_cache_addr", ga, vecs[i].exp_cache_addr);
            chk("tbl_index", line_index(ga), vecs[i].exp_index);
            if (i == 0) begin
                line_t2 = gl;
                chk("t2_word0", gl[511:480], 32'hA000_0000);
                chk("t2_word15", gl[31:0], 32'hA000_000F);
            end
            if (i == 1) begin
                chk("t3_req_cycles", rq, 64);
                chk("t3_same_line", gl, line_t2);
            end
            last_addr = ga;
            last_line = gl;
        end

        // Spurious acks in IDLE; write outputs hold their last line.
        bus.miss_req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            seen |= bus.mem_req | bus.write_cache | bus.refill_done | bus.stall;
        end
        chk("spurious_idle", seen, 0);
        chk("hold_cache_addr", bus.cache_addr, last_addr);
        chk("hold_cache_data", bus.cache_data_in, last_line);
        bus.mem_ack = 1'b0;
        @(negedge clk);

        // Reset after beat 7 acked, then a fresh miss from beat 0.
        abort_refill(32'h0000_3000, 9);
        do_refill(32'h0000_0040, 0, 1'b0, 1'b0, lat, rq, ga, gl);
        chk("after_abort_addr", ga, 32'h0000_0040);

        // Reset coincident with the beat-15 ack.
        bus.miss_req = 1'b0;
        @(negedge clk);
        abort_refill(32'h0000_5A80, 16);

        // Randomized refills with random waits, addresses and back-to-back chaining.
        use_hash = 1'b1;
        salt     = $urandom;
        for (int i = 0; i < 20; i++) begin
            do_refill($urandom, 0, 1'b1, (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0, lat, rq, ga, gl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill.md
# cache_refill

Line-refill engine for the 32-line, 512-bit-block direct-mapped cache. On a read miss it fetches the 16 words of the missing line from main memory over a 32-bit request/acknowledge port and assembles them into a 512-bit block. It then writes the block into the cache with a one-cycle `write_cache` pulse, setting the valid bit. It sits between the CPU stall logic and the memory port, on the fill side of the cache.

## Interface
- `LINE_WORDS`, 16: words per cache line (fixed by the 512-bit block).
- `WORD_W`, 32: memory word width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `miss_req` in 1: refill request from lookup (`read & !ishit`), held until satisfied.
- `miss_addr` in 32: byte address that missed.
- `stall` out 1: CPU hold while a refill is pending or running.
- `mem_req` out 1: memory read request.
- `mem_addr` out 32: word-aligned memory read address.
- `mem_ack` in 1: memory read data valid this cycle.
- `mem_rdata` in 32: memory read data.
- `write_cache` out 1: one-cycle cache line write strobe.
- `cache_addr` out 32: line base address driven to the cache; index is bits [10:6].
- `cache_data_in` out 512: assembled line; word k occupies bits [511-32k : 480-32k].
- `refill_done` out 1: one-cycle pulse when the line is valid in the cache.

## Operation
- States:
  - IDLE: accept a miss.
  - REQ: fetch the beats.
  - WRITE: issue the cache write.
  - DONE: signal completion.
- IDLE:
  - If `miss_req`=1: latch base = {`miss_addr`[31:6], 6'b0}, clear the beat counter (4-bit), go to REQ.
  - Else: stay in IDLE.
- REQ:
  - `mem_req`=1 and `mem_addr` = base + 4·beat.
  - Both are held stable until `mem_ack`=1 is sampled.
  - On each edge with `mem_ack`=1: `mem_rdata` goes into word slot `beat`, and the beat counter increments.
  - If beat was 15: go to WRITE and drop `mem_req`.
- WRITE:
  - `write_cache`=1 for exactly one cycle.
  - `cache_addr` = base; `cache_data_in` = assembled line.
  - Next state is DONE.
- DONE:
  - `refill_done`=1 for one cycle, then IDLE.
  - The cache line is already written, so the lookup now hits and `miss_req` has fallen combinationally.
- `stall` = `miss_req` in IDLE, 1 in REQ and WRITE, 0 in DONE. This is the only combinational output.
- `mem_ack` is ignored outside REQ.
- `mem_rdata` is captured only on an acknowledged REQ cycle.
- `miss_req`/`miss_addr` changes outside IDLE are ignored; the latched base is used throughout.
- The beat counter wraps 15→0 only by leaving REQ. No partial line is ever written.
- `cache_addr` and `cache_data_in` hold their last values outside WRITE; the cache only samples them with `write_cache`.

## Timing
- Reset (`reset`=0 at an edge) forces, at that edge:
  - state = IDLE, beat = 0, base = 0;
  - `mem_req`=0, `mem_addr`=0, `write_cache`=0, `cache_addr`=0, `cache_data_in`=0, `refill_done`=0.
- `stall` follows `miss_req` after reset.
- Reset mid-refill (REQ or WRITE) aborts the refill:
  - no `write_cache` pulse;
  - the partial line is discarded;
  - a new miss restarts at beat 0.
- `mem_req`/`mem_addr` are registered:
  - they rise on the edge that accepts the miss;
  - a new address appears on the edge after each ack.
- Latency with zero-wait memory (ack in every REQ cycle):
  - 16 REQ cycles, then 1 WRITE, then 1 DONE;
  - `refill_done` comes 18 cycles after the accepting edge.
- Each memory wait cycle adds one cycle.
- Simultaneous `mem_ack` on beat 15 and `reset`=0: reset wins, no write.
- A new miss can be accepted on the first IDLE cycle after DONE. There is no dead cycle beyond DONE.

## Structure
- `cache_pkg` holds:
  - constants `LINE_WORDS`=16, `WORD_W`=32, `LINE_W`=512, `OFFSET_BITS`=6, `INDEX_BITS`=5;
  - the state enum `refill_state_t` {IDLE, REQ, WRITE, DONE};
  - the beat counter type.
- One natural sub-module, `line_assembler`:
  - a 16×32 slot register with a load-enable and a 4-bit slot select;
  - it outputs the 512-bit line with word 0 in the MSBs.
- The FSM, beat counter and address generation stay in `cache_refill`.

## Test plan
1. Reset: hold `reset`=0 for 2 cycles with `miss_req`=1 → all registered outputs 0; `stall`=1; no `mem_req` until `reset`=1.
2. Zero-wait refill of `miss_addr`=0x0000_1234, memory returning 0xA000_0000+k for word k:
   - `mem_addr` steps 0x1200, 0x1204 … 0x123C;
   - `write_cache` is high for one cycle with `cache_addr`=0x1200, `cache_data_in`[511:480]=0xA000_0000 and [31:0]=0xA000_000F;
   - `refill_done` falls on cycle 18.
3. Wait states (ack 3 cycles after each request) → `mem_addr`/`mem_req` stable during waits; 64 REQ cycles; line contents identical to test 2.
4. `reset`=0 after beat 7 is acked → `mem_req`=0 next cycle; no `write_cache`; a following miss to 0x0000_0040 starts at `mem_addr`=0x40.
5. Spurious `mem_ack`=1 with `mem_rdata`=0xDEAD_BEEF in IDLE and in DONE → no state change; the value never appears in any line.
6. Back-to-back misses 0x0000_07C0 then 0x0000_0800 → second accepted on the cycle after the first `refill_done`; `cache_addr` 0x7C0 then 0x800 (indices 31 then 0).
